bus_dma_master: RTL
===================

Name: bus_dma_master

Overview:
- Bus initiator for the shared 8-bit tri-state system bus (BUS_ADDR, BUS_DATA, BUS_WE).
- Copies a block of LEN bytes from SRC_ADDR to DST_ADDR through any bus responder. It obeys the RAM responder's timing: read data is driven one cycle after the address is sampled.
- Sits beside the processor. It requests bus ownership with BUS_REQ/BUS_GNT, so the processor can offload memory-to-memory and memory-to-peripheral moves.

Parameters:
- PARK_ADDR, 8'h90, unmapped address driven during turnaround so that no responder drives BUS_DATA.
- CNT_WIDTH, 8, width of the length and remaining-byte counter.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; samples SRC_ADDR/DST_ADDR/LEN when IDLE.
- SRC_ADDR  in  8  first source byte address.
- DST_ADDR  in  8  first destination byte address.
- LEN  in  CNT_WIDTH  number of bytes to copy.
- BUSY  out  1  high from the accepted START until DONE.
- DONE  out  1  one-cycle pulse when the transfer completes.
- REMAINING  out  CNT_WIDTH  bytes not yet written.
- BUS_REQ  out  1  bus ownership request.
- BUS_GNT  in  1  ownership grant from the arbiter.
- BUS_ADDR  out  8  tri-stated (Z) unless owning the bus.
- BUS_WE  out  1  tri-stated (Z) unless owning the bus.
- BUS_DATA  inout  8  driven only in WRITE, otherwise Z.

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE; BUSY=0, DONE=0, REMAINING=0, BUS_REQ=0.
  - BUS_ADDR, BUS_WE and BUS_DATA at Z.
  - Internal src/dst/data registers cleared.
  - Reset asserted mid-transfer abandons the transfer immediately with no DONE. A destination write in flight may or may not land.
- States: IDLE, REQ, RD_ADDR, RD_WAIT, TURN, WRITE, FIN.
- IDLE:
  - START with LEN=0 -> FIN (no bus request, DONE still pulses).
  - START with LEN>0 -> latch inputs, REMAINING=LEN, BUSY=1, go to REQ.
  - START is ignored whenever not IDLE.
- REQ:
  - BUS_REQ=1, bus outputs Z.
  - BUS_GNT=1 -> RD_ADDR.
- RD_ADDR (cycle 1 of byte):
  - drive BUS_ADDR=src, BUS_WE=0, BUS_DATA=Z.
- RD_WAIT (cycle 2):
  - hold src/WE=0.
  - The responder drives data during this cycle; capture BUS_DATA into the data register at the end of the cycle.
- TURN (cycle 3):
  - BUS_ADDR=PARK_ADDR, BUS_WE=0, BUS_DATA=Z.
  - Absorbs the responder's extra drive cycle so there is no contention.
- WRITE (cycle 4):
  - BUS_ADDR=dst, BUS_WE=1, BUS_DATA=data.
  - At the end of the cycle: src+=1, dst+=1 (modulo 256, 8'hFF wraps to 8'h00), REMAINING-=1.
  - If REMAINING becomes 0 -> FIN.
  - Else if BUS_GNT=1 -> RD_ADDR.
  - Else release the bus (outputs Z, BUS_REQ stays 1) -> REQ.
- Grant is sampled only at byte boundaries (REQ and end of WRITE). A grant drop inside a byte is ignored until the byte finishes.
- FIN:
  - DONE=1 for exactly one cycle; BUSY=0 and BUS_REQ=0 from the following cycle.
  - Bus outputs Z.
  - Return to IDLE.
- Throughput: 4 cycles per byte with a continuous grant. A LEN=N transfer takes 4N+2 cycles from START to DONE, with a 1-cycle grant.
- Copies run forward byte by byte. Overlapping regions with dst>src replicate source bytes; this is defined behaviour, not an error.
- LEN=255 with full wrap is legal. Addresses simply wrap.

Decomposition:
- Shared bus package/header (bus_defs):
  - state encoding localparams;
  - bus map constants (RAM base 8'h00 size 128, peripheral window 8'hC0–8'hFF, default PARK_ADDR).
- Single flat module, no sub-module. The tri-state drive is three continuous assigns gated by own_bus/drive_data flags.

Test Plan:
- Copy: RAM preloaded Mem[0x10..0x12]=A1,B2,C3; START src=0x10 dst=0x40 LEN=3, GNT tied 1 -> Mem[0x40..0x42]=A1,B2,C3; DONE at cycle 14 after START; REMAINING 3->0.
- LEN=0 -> DONE pulses within 2 cycles; BUS_REQ never asserted; bus stays Z.
- Grant withheld: GNT=0 for 5 cycles after START, then 1 -> bus Z and BUS_REQ=1 throughout the wait; copy completes correctly afterward.
- Grant dropped after byte 1 of 3 -> bus released after the first WRITE; resumes at byte 2 on re-grant; final memory correct.
- Wrap: src=0x7F dst=0xFF LEN=2 -> reads 0x7F,0x80 and writes 0xFF,0x00. Check 0x00 holds Mem[0x80]'s bus value; no X on BUS_DATA (no contention) in any cycle.
- Reset asserted during RD_WAIT of byte 2 -> outputs immediately Z/0, BUSY=0, no DONE; a subsequent START runs normally.

Source files
------------

// File: rtl/bus_dma_master_pkg.sv
// ============================================================================
// Module      : bus_dma_master_pkg
// Description : State encoding and system bus map shared by the bus DMA master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_dma_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_TURN    = 3'd4,
        ST_WRITE   = 3'd5,
        ST_FIN     = 3'd6
    } dma_state_t;

    // System bus map; the park address sits in a hole no responder decodes.
    localparam logic [7:0] RAM_BASE          = 8'h00;
    localparam int         RAM_SIZE          = 128;
    localparam logic [7:0] PERIPH_BASE       = 8'hC0;
    localparam logic [7:0] PERIPH_LAST       = 8'hFF;
    localparam logic [7:0] DEFAULT_PARK_ADDR = 8'h90;

    function automatic logic [7:0] next_addr(input logic [7:0] addr);
        return addr + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_dma_master.sv
// ============================================================================
// Module      : bus_dma_master
// Description : Block copy engine that owns the shared 8-bit tri-state bus on grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_dma_master
    import bus_dma_master_pkg::*;
#(
    parameter logic [7:0] PARK_ADDR = DEFAULT_PARK_ADDR,
    parameter int         CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [7:0]           src_addr,
    input  logic [7:0]           dst_addr,
    input  logic [CNT_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] remaining,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output wire  [7:0]           bus_addr,
    output wire                  bus_we,
    inout  wire  [7:0]           bus_data
);

    dma_state_t r_state;
    dma_state_t w_next_state;

    logic [7:0]           r_src;
    logic [7:0]           r_dst;
    logic [7:0]           r_data;
    logic [CNT_WIDTH-1:0] r_remaining;

    logic       w_own_bus;
    logic       w_drive_data;
    logic [7:0] w_addr;
    logic       w_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_data      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src       <= src_addr;
                        r_dst       <= dst_addr;
                        r_remaining <= len;
                    end
                end
                ST_RD_WAIT: begin
                    r_data <= bus_data;
                end
                ST_WRITE: begin
                    r_src       <= next_addr(r_src);
                    r_dst       <= next_addr(r_dst);
                    r_remaining <= r_remaining - CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        bus_req      = 1'b0;
        done         = 1'b0;
        w_own_bus    = 1'b0;
        w_drive_data = 1'b0;
        w_addr       = PARK_ADDR;
        w_we         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (len == '0) ? ST_FIN : ST_REQ;
                end
            end
            ST_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    w_next_state = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                bus_req      = 1'b1;
                w_own_bus    = 1'b1;
                w_addr       = r_src;
                w_next_state = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                bus_req      = 1'b1;
                w_own_bus    = 1'b1;
                w_addr       = r_src;
                w_next_state = ST_TURN;
            end
            // Responder still drives for one more cycle; park on an unmapped address.
            ST_TURN: begin
                bus_req      = 1'b1;
                w_own_bus    = 1'b1;
                w_addr       = PARK_ADDR;
                w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                bus_req      = 1'b1;
                w_own_bus    = 1'b1;
                w_drive_data = 1'b1;
                w_addr       = r_dst;
                w_we         = 1'b1;
                if (r_remaining == CNT_WIDTH'(1)) begin
                    w_next_state = ST_FIN;
                end else if (bus_gnt) begin
                    w_next_state = ST_RD_ADDR;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_FIN: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign busy      = (r_state != ST_IDLE);
    assign remaining = r_remaining;

    assign bus_addr = w_own_bus    ? w_addr : 8'hzz;
    assign bus_we   = w_own_bus    ? w_we   : 1'bz;
    assign bus_data = w_drive_data ? r_data : 8'hzz;

endmodule

`default_nettype wire
